// File: rtl/psram_req_sched_if.sv
// Request/completion bundle between the two requesters, the scheduler and psram_core.
// The scheduler takes the slave view; requesters and core together take the master view.
interface psram_req_sched_if #(
  parameter int unsigned ADDR_WIDTH = 26
);
  logic                  en_i;
  logic                  usr_req_i;
  logic                  usr_wen_i;
  logic [ADDR_WIDTH-1:0] usr_addr_i;
  logic [31:0]           usr_wdata_i;
  logic [3:0]            usr_bm_i;
  logic                  usr_gnt_o;
  logic                  usr_done_o;
  logic [31:0]           usr_rdata_o;
  logic                  cfg_req_i;
  logic                  cfg_wen_i;
  logic [7:0]            cfg_wdata_i;
  logic                  cfg_gnt_o;
  logic                  cfg_done_o;
  logic [7:0]            cfg_rdata_o;
  logic                  core_start_o;
  logic                  core_cfg_o;
  logic                  core_wen_o;
  logic [ADDR_WIDTH-1:0] core_addr_o;
  logic [31:0]           core_wdata_o;
  logic [3:0]            core_bm_o;
  logic                  core_done_i;
  logic [31:0]           core_rdata_i;
  logic                  err_o;
  logic                  tmo_o;
  logic                  tmo_clr_i;
  logic                  busy_o;

  modport slave (
    input  en_i, usr_req_i, usr_wen_i, usr_addr_i, usr_wdata_i, usr_bm_i,
    input  cfg_req_i, cfg_wen_i, cfg_wdata_i, core_done_i, core_rdata_i, tmo_clr_i,
    output usr_gnt_o, usr_done_o, usr_rdata_o, cfg_gnt_o, cfg_done_o, cfg_rdata_o,
    output core_start_o, core_cfg_o, core_wen_o, core_addr_o, core_wdata_o, core_bm_o,
    output err_o, tmo_o, busy_o
  );

  modport master (
    output en_i, usr_req_i, usr_wen_i, usr_addr_i, usr_wdata_i, usr_bm_i,
    output cfg_req_i, cfg_wen_i, cfg_wdata_i, core_done_i, core_rdata_i, tmo_clr_i,
    input  usr_gnt_o, usr_done_o, usr_rdata_o, cfg_gnt_o, cfg_done_o, cfg_rdata_o,
    input  core_start_o, core_cfg_o, core_wen_o, core_addr_o, core_wdata_o, core_bm_o,
    input  err_o, tmo_o, busy_o
  );
endinterface

// File: rtl/psram_req_sched.sv
// Round-robin scheduler sharing one psram_core between the AXI user path and the APB
// config path, with a watchdog that aborts a hung core transaction.
module psram_req_sched #(
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input logic                clk_i,
  input logic                rst_i,
  psram_req_sched_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);

  state_e                state_q;
  logic                  prio_cfg_q;
  logic [15:0]           wdog_q;
  logic                  usr_gnt_q, cfg_gnt_q, usr_done_q, cfg_done_q;
  logic [31:0]           usr_rdata_q;
  logic [7:0]            cfg_rdata_q;
  logic                  core_start_q, core_cfg_q, core_wen_q;
  logic [ADDR_WIDTH-1:0] core_addr_q;
  logic [31:0]           core_wdata_q;
  logic [3:0]            core_bm_q;
  logic                  err_q, tmo_q;

  logic grant, pick_cfg;

  always_comb begin
    grant    = bus.en_i & (bus.usr_req_i | bus.cfg_req_i);
    // prio_cfg_q names the side that was not served last
    pick_cfg = bus.cfg_req_i & (~bus.usr_req_i | prio_cfg_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      prio_cfg_q   <= 1'b0;
      wdog_q       <= '0;
      usr_gnt_q    <= 1'b0;
      cfg_gnt_q    <= 1'b0;
      usr_done_q   <= 1'b0;
      cfg_done_q   <= 1'b0;
      usr_rdata_q  <= '0;
      cfg_rdata_q  <= '0;
      core_start_q <= 1'b0;
      core_cfg_q   <= 1'b0;
      core_wen_q   <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      core_bm_q    <= '0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      usr_gnt_q    <= 1'b0;
      cfg_gnt_q    <= 1'b0;
      usr_done_q   <= 1'b0;
      cfg_done_q   <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      if (bus.tmo_clr_i) tmo_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant) begin
            core_cfg_q <= pick_cfg;
            prio_cfg_q <= ~pick_cfg;
            if (pick_cfg) begin
              cfg_gnt_q    <= 1'b1;
              core_wen_q   <= bus.cfg_wen_i;
              core_addr_q  <= '0;
              core_wdata_q <= {24'h0, bus.cfg_wdata_i};
              core_bm_q    <= 4'b0001;
            end else begin
              usr_gnt_q    <= 1'b1;
              core_wen_q   <= bus.usr_wen_i;
              core_addr_q  <= bus.usr_addr_i;
              core_wdata_q <= bus.usr_wdata_i;
              core_bm_q    <= bus.usr_bm_i;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          core_start_q <= 1'b1;
          wdog_q       <= '0;
          state_q      <= StWait;
        end
        StWait: begin
          if (bus.core_done_i) begin
            // Completion is registered here so the done pulse lands in the RESP cycle
            if (core_cfg_q) begin
              cfg_done_q  <= 1'b1;
              cfg_rdata_q <= bus.core_rdata_i[7:0];
            end else begin
              usr_done_q  <= 1'b1;
              usr_rdata_q <= bus.core_rdata_i;
            end
            state_q <= StResp;
          end else if (wdog_q >= WdogLast) begin
            err_q <= 1'b1;
            tmo_q <= 1'b1;
            if (core_cfg_q) begin
              cfg_done_q  <= 1'b1;
              cfg_rdata_q <= '0;
            end else begin
              usr_done_q  <= 1'b1;
              usr_rdata_q <= '0;
            end
            state_q <= StIdle;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.usr_gnt_o    = usr_gnt_q;
  assign bus.usr_done_o   = usr_done_q;
  assign bus.usr_rdata_o  = usr_rdata_q;
  assign bus.cfg_gnt_o    = cfg_gnt_q;
  assign bus.cfg_done_o   = cfg_done_q;
  assign bus.cfg_rdata_o  = cfg_rdata_q;
  assign bus.core_start_o = core_start_q;
  assign bus.core_cfg_o   = core_cfg_q;
  assign bus.core_wen_o   = core_wen_q;
  assign bus.core_addr_o  = core_addr_q;
  assign bus.core_wdata_o = core_wdata_q;
  assign bus.core_bm_o    = core_bm_q;
  assign bus.err_o        = err_q;
  assign bus.tmo_o        = tmo_q;
  assign bus.busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_psram_req_sched.sv
// Bench for psram_req_sched: directed scenarios plus randomized transactions checked
// against a transaction-level model of arbitration, latency and watchdog abort.
module tb_psram_req_sched;
  localparam int unsigned AW   = 26;
  localparam int unsigned WDOG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  psram_req_sched_if #(.ADDR_WIDTH(AW)) bus ();

  psram_req_sched #(
    .ADDR_WIDTH (AW),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.usr_gnt_o, bus.usr_done_o, bus.cfg_gnt_o, bus.cfg_done_o, bus.core_start_o,
         bus.core_cfg_o, bus.core_wen_o, bus.err_o, bus.tmo_o, bus.busy_o} !== 10'b0)
      $display("FAIL reset_flags: got %b want 0", {bus.usr_gnt_o, bus.usr_done_o,
               bus.cfg_gnt_o, bus.cfg_done_o, bus.core_start_o, bus.core_cfg_o,
               bus.core_wen_o, bus.err_o, bus.tmo_o, bus.busy_o});
    else n_pass++;
    n_checks++;
    if ({bus.core_addr_o, bus.core_wdata_o, bus.core_bm_o, bus.usr_rdata_o,
         bus.cfg_rdata_o} !== '0)
      $display("FAIL reset_data: addr %h wdata %h bm %h urd %h crd %h want 0",
               bus.core_addr_o, bus.core_wdata_o, bus.core_bm_o, bus.usr_rdata_o,
               bus.cfg_rdata_o);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_user_write();
    bus.en_i = 1'b1;
    bus.usr_req_i = 1'b1; bus.usr_wen_i = 1'b1; bus.usr_addr_i = 26'h100;
    bus.usr_wdata_i = 32'hA5A5_5A5A; bus.usr_bm_i = 4'hF;
    step();
    n_checks++;
    if ({bus.usr_gnt_o, bus.cfg_gnt_o, bus.core_start_o} !== 3'b100)
      $display("FAIL uw_gnt: gnt/cgnt/start %b want 100",
               {bus.usr_gnt_o, bus.cfg_gnt_o, bus.core_start_o});
    else n_pass++;
    bus.usr_req_i = 1'b0;
    step();
    n_checks++;
    if ({bus.core_start_o, bus.core_cfg_o, bus.core_wen_o, bus.core_addr_o, bus.core_wdata_o,
         bus.core_bm_o} !== {3'b101, 26'h100, 32'hA5A5_5A5A, 4'hF})
      $display("FAIL uw_start: start %b cfg %b wen %b addr %h wdata %h bm %h",
               bus.core_start_o, bus.core_cfg_o, bus.core_wen_o, bus.core_addr_o,
               bus.core_wdata_o, bus.core_bm_o);
    else n_pass++;
    repeat (5) step();
    bus.core_done_i = 1'b1; bus.core_rdata_i = 32'h1357_9BDF;
    step();
    bus.core_done_i = 1'b0;
    n_checks++;
    if ({bus.usr_done_o, bus.cfg_done_o, bus.busy_o} !== 3'b101)
      $display("FAIL uw_done: udone/cdone/busy %b want 101",
               {bus.usr_done_o, bus.cfg_done_o, bus.busy_o});
    else n_pass++;
    step();
    n_checks++;
    if ({bus.usr_done_o, bus.busy_o} !== 2'b00)
      $display("FAIL uw_idle: udone/busy %b want 00", {bus.usr_done_o, bus.busy_o});
    else n_pass++;
  endtask

  task automatic test_cfg_read();
    bus.cfg_req_i = 1'b1; bus.cfg_wen_i = 1'b0; bus.cfg_wdata_i = 8'h3C;
    step();
    n_checks++;
    if ({bus.usr_gnt_o, bus.cfg_gnt_o} !== 2'b01)
      $display("FAIL cr_gnt: ugnt/cgnt %b want 01", {bus.usr_gnt_o, bus.cfg_gnt_o});
    else n_pass++;
    bus.cfg_req_i = 1'b0;
    step();
    n_checks++;
    if ({bus.core_start_o, bus.core_cfg_o, bus.core_wen_o, bus.core_addr_o, bus.core_wdata_o,
         bus.core_bm_o} !== {3'b110, 26'h0, 32'h0000_003C, 4'b0001})
      $display("FAIL cr_start: start %b cfg %b wen %b addr %h wdata %h bm %h",
               bus.core_start_o, bus.core_cfg_o, bus.core_wen_o, bus.core_addr_o,
               bus.core_wdata_o, bus.core_bm_o);
    else n_pass++;
    step();
    bus.core_done_i = 1'b1; bus.core_rdata_i = 32'h1234_568D;
    step();
    bus.core_done_i = 1'b0;
    n_checks++;
    if ({bus.cfg_done_o, bus.usr_done_o, bus.cfg_rdata_o} !== {2'b10, 8'h8D})
      $display("FAIL cr_done: cdone %b udone %b rdata %h want 1 0 8d",
               bus.cfg_done_o, bus.usr_done_o, bus.cfg_rdata_o);
    else n_pass++;
    step();
  endtask

  task automatic test_round_robin();
    int  ndone = 0;
    int  outstanding = 0;
    int  cnt = 0;
    bit  exp_cfg = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.en_i = 1'b1;
    bus.usr_req_i = 1'b1; bus.usr_wen_i = 1'b0; bus.usr_addr_i = 26'h40;
    bus.cfg_req_i = 1'b1; bus.cfg_wen_i = 1'b1; bus.cfg_wdata_i = 8'h11;
    for (int cyc = 0; cyc < 150 && ndone < 4; cyc++) begin
      step();
      bus.core_done_i = 1'b0;
      if (bus.usr_gnt_o || bus.cfg_gnt_o) begin
        n_checks++;
        if ({bus.usr_gnt_o, bus.cfg_gnt_o} !== {!exp_cfg, exp_cfg} || outstanding != 0)
          $display("FAIL rr_grant: ugnt/cgnt %b want %b outstanding %0d want 0",
                   {bus.usr_gnt_o, bus.cfg_gnt_o}, {!exp_cfg, exp_cfg}, outstanding);
        else n_pass++;
        outstanding = 1;
        exp_cfg = !exp_cfg;
      end
      if (bus.core_start_o) cnt = 2;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.core_done_i = 1'b1;
      end
      if (bus.usr_done_o || bus.cfg_done_o) begin
        outstanding = 0;
        ndone++;
        if (ndone == 4) begin
          bus.usr_req_i = 1'b0;
          bus.cfg_req_i = 1'b0;
        end
      end
    end
    n_checks++;
    if (ndone != 4) $display("FAIL rr_count: done pulses %0d want 4", ndone);
    else n_pass++;
    bus.usr_req_i = 1'b0; bus.cfg_req_i = 1'b0; bus.core_done_i = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.busy_o !== 1'b0) $display("FAIL rr_drain: busy %b want 0", bus.busy_o);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int early = 0;
    for (int pass = 0; pass < 2; pass++) begin
      early = 0;
      if (pass == 0) begin
        bus.usr_req_i = 1'b1; bus.usr_wen_i = 1'b0; bus.usr_addr_i = 26'h2000;
      end else begin
        bus.cfg_req_i = 1'b1; bus.cfg_wen_i = 1'b0;
        bus.tmo_clr_i = 1'b1;
      end
      step();
      bus.usr_req_i = 1'b0; bus.cfg_req_i = 1'b0;
      step();
      n_checks++;
      if (bus.core_start_o !== 1'b1) $display("FAIL to_start%0d: start %b want 1", pass,
                                              bus.core_start_o);
      else n_pass++;
      repeat (WDOG - 1) begin
        step();
        if (bus.err_o || bus.usr_done_o || bus.cfg_done_o) early++;
      end
      step();
      n_checks++;
      if (early != 0 || {bus.err_o, bus.tmo_o, bus.busy_o} !== 3'b110)
        $display("FAIL to_abort%0d: early %0d err/tmo/busy %b want 0 110", pass, early,
                 {bus.err_o, bus.tmo_o, bus.busy_o});
      else n_pass++;
      n_checks++;
      if (pass == 0 && {bus.usr_done_o, bus.cfg_done_o, bus.usr_rdata_o} !== {2'b10, 32'h0} ||
          pass == 1 && {bus.usr_done_o, bus.cfg_done_o, bus.cfg_rdata_o} !== {2'b01, 8'h0})
        $display("FAIL to_done%0d: udone %b cdone %b urd %h crd %h", pass, bus.usr_done_o,
                 bus.cfg_done_o, bus.usr_rdata_o, bus.cfg_rdata_o);
      else n_pass++;
      bus.tmo_clr_i = 1'b0;
      bus.core_done_i = 1'b1; bus.core_rdata_i = 32'hDEAD_BEEF;
      step();
      bus.core_done_i = 1'b0;
      step();
      n_checks++;
      if ({bus.usr_done_o, bus.cfg_done_o, bus.err_o, bus.busy_o, bus.tmo_o} !== 5'b00001)
        $display("FAIL to_late%0d: udone/cdone/err/busy/tmo %b want 00001", pass,
                 {bus.usr_done_o, bus.cfg_done_o, bus.err_o, bus.busy_o, bus.tmo_o});
      else n_pass++;
      bus.tmo_clr_i = 1'b1;
      step();
      bus.tmo_clr_i = 1'b0;
      n_checks++;
      if (bus.tmo_o !== 1'b0) $display("FAIL to_clr%0d: tmo %b want 0", pass, bus.tmo_o);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    int g = 0;
    bus.en_i = 1'b0;
    bus.usr_req_i = 1'b1; bus.usr_wen_i = 1'b1; bus.usr_addr_i = 26'h3FF_FFFC;
    bus.usr_wdata_i = 32'h0BAD_F00D; bus.usr_bm_i = 4'h6;
    repeat (6) begin
      step();
      if (bus.usr_gnt_o || bus.cfg_gnt_o || bus.busy_o) g++;
    end
    n_checks++;
    if (g != 0) $display("FAIL en_block: %0d cycles with grant/busy want 0", g);
    else n_pass++;
    bus.en_i = 1'b1;
    step();
    n_checks++;
    if (bus.usr_gnt_o !== 1'b1) $display("FAIL en_gnt: ugnt %b want 1", bus.usr_gnt_o);
    else n_pass++;
    bus.usr_req_i = 1'b0;
    step();
    bus.en_i = 1'b0;
    repeat (3) step();
    bus.core_done_i = 1'b1; bus.core_rdata_i = 32'h7777_0001;
    step();
    bus.core_done_i = 1'b0;
    n_checks++;
    if ({bus.usr_done_o, bus.err_o, bus.usr_rdata_o} !== {2'b10, 32'h7777_0001})
      $display("FAIL en_drop: udone %b err %b rdata %h want 1 0 77770001",
               bus.usr_done_o, bus.err_o, bus.usr_rdata_o);
    else n_pass++;
    step();
    bus.en_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus.usr_req_i = 1'b1; bus.usr_wen_i = 1'b0; bus.usr_addr_i = 26'h55;
    step();
    bus.usr_req_i = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({bus.busy_o, bus.core_start_o, bus.usr_done_o, bus.cfg_done_o, bus.err_o} !== 5'b0)
      $display("FAIL rm_idle: busy/start/udone/cdone/err %b want 00000", {bus.busy_o,
               bus.core_start_o, bus.usr_done_o, bus.cfg_done_o, bus.err_o});
    else n_pass++;
    bus.core_done_i = 1'b1;
    step();
    bus.core_done_i = 1'b0;
    n_checks++;
    if ({bus.usr_done_o, bus.cfg_done_o, bus.busy_o} !== 3'b0)
      $display("FAIL rm_stray: udone/cdone/busy %b want 000",
               {bus.usr_done_o, bus.cfg_done_o, bus.busy_o});
    else n_pass++;
    bus.cfg_req_i = 1'b1; bus.cfg_wen_i = 1'b1; bus.cfg_wdata_i = 8'hE7;
    step();
    bus.cfg_req_i = 1'b0;
    step();
    n_checks++;
    if ({bus.core_start_o, bus.core_cfg_o, bus.core_wdata_o} !== {2'b11, 32'h0000_00E7})
      $display("FAIL rm_start: start %b cfg %b wdata %h want 1 1 000000e7",
               bus.core_start_o, bus.core_cfg_o, bus.core_wdata_o);
    else n_pass++;
    bus.core_done_i = 1'b1; bus.core_rdata_i = 32'h0;
    step();
    bus.core_done_i = 1'b0;
    n_checks++;
    if (bus.cfg_done_o !== 1'b1) $display("FAIL rm_done: cdone %b want 1", bus.cfg_done_o);
    else n_pass++;
    step();
  endtask

  // Model: a winner is whoever requests alone, else the side not served last; a transaction
  // completes if the core answers within WDOG cycles of start, else it is aborted with data 0.
  task automatic test_random();
    bit                served_cfg_last = 1'b1;
    bit                win_cfg, hit, to, fin;
    int unsigned       r, lat;
    logic [AW-1:0]     ua, exp_addr;
    logic [31:0]       uw, rd, exp_wdata;
    logic [3:0]        ubm, exp_bm;
    logic [7:0]        cw;
    logic              uwen, cwen, exp_wen;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.en_i = 1'b1;
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(1, 3);
      ua = AW'($urandom); uw = $urandom; ubm = 4'($urandom); uwen = 1'($urandom);
      cw = 8'($urandom); cwen = 1'($urandom); rd = $urandom;
      lat = ($urandom_range(0, 3) == 0) ? WDOG - 1 + $urandom_range(0, 2)
                                         : $urandom_range(0, 6);
      bus.usr_req_i = r[0]; bus.usr_addr_i = ua; bus.usr_wdata_i = uw;
      bus.usr_bm_i = ubm; bus.usr_wen_i = uwen;
      bus.cfg_req_i = r[1]; bus.cfg_wdata_i = cw; bus.cfg_wen_i = cwen;
      win_cfg = r[1] && (!r[0] || !served_cfg_last);
      served_cfg_last = win_cfg;
      exp_addr  = win_cfg ? '0 : ua;
      exp_wdata = win_cfg ? {24'h0, cw} : uw;
      exp_bm    = win_cfg ? 4'b0001 : ubm;
      exp_wen   = win_cfg ? cwen : uwen;
      step();
      bus.usr_req_i = 1'b0; bus.cfg_req_i = 1'b0;
      n_checks++;
      if ({bus.usr_gnt_o, bus.cfg_gnt_o} !== {!win_cfg, win_cfg})
        $display("FAIL rnd_gnt[%0d]: ugnt/cgnt %b want %b", it,
                 {bus.usr_gnt_o, bus.cfg_gnt_o}, {!win_cfg, win_cfg});
      else n_pass++;
      step();
      n_checks++;
      if ({bus.core_start_o, bus.core_cfg_o, bus.core_wen_o, bus.core_addr_o, bus.core_wdata_o,
           bus.core_bm_o} !== {1'b1, win_cfg, exp_wen, exp_addr, exp_wdata, exp_bm})
        $display("FAIL rnd_issue[%0d]: cfg %b wen %b addr %h wdata %h bm %h want %b %b %h %h %h",
                 it, bus.core_cfg_o, bus.core_wen_o, bus.core_addr_o, bus.core_wdata_o,
                 bus.core_bm_o, win_cfg, exp_wen, exp_addr, exp_wdata, exp_bm);
      else n_pass++;
      fin = 1'b0;
      to  = 1'b0;
      for (int k = 0; k < int'(WDOG) + 4 && !fin; k++) begin
        bus.core_done_i = (k == int'(lat));
        bus.core_rdata_i = rd;
        step();
        bus.core_done_i = 1'b0;
        hit = (k == int'(lat)) && (lat < WDOG);
        to  = (k == int'(WDOG) - 1) && (lat >= WDOG);
        n_checks++;
        if ({bus.usr_done_o, bus.cfg_done_o, bus.err_o, bus.usr_gnt_o, bus.cfg_gnt_o,
             bus.core_start_o} !== {(hit || to) && !win_cfg, (hit || to) && win_cfg, to, 3'b0})
          $display("FAIL rnd_wait[%0d] k=%0d: udone/cdone/err/gnts/start %b lat %0d", it, k,
                   {bus.usr_done_o, bus.cfg_done_o, bus.err_o, bus.usr_gnt_o, bus.cfg_gnt_o,
                    bus.core_start_o}, lat);
        else n_pass++;
        if (hit || to) begin
          fin = 1'b1;
          n_checks++;
          if (win_cfg ? (bus.cfg_rdata_o !== (to ? 8'h0 : rd[7:0]))
                      : (bus.usr_rdata_o !== (to ? 32'h0 : rd)) || (to && bus.tmo_o !== 1'b1))
            $display("FAIL rnd_rdata[%0d]: urd %h crd %h tmo %b sent %h timeout %b", it,
                     bus.usr_rdata_o, bus.cfg_rdata_o, bus.tmo_o, rd, to);
          else n_pass++;
        end
      end
      if (to) bus.core_done_i = 1'b1;
      step();
      bus.core_done_i = 1'b0;
      n_checks++;
      if ({bus.busy_o, bus.usr_done_o, bus.cfg_done_o, bus.err_o} !== 4'b0)
        $display("FAIL rnd_after[%0d]: busy/udone/cdone/err %b want 0000", it,
                 {bus.busy_o, bus.usr_done_o, bus.cfg_done_o, bus.err_o});
      else n_pass++;
      if (to) begin
        bus.tmo_clr_i = 1'b1;
        step();
        bus.tmo_clr_i = 1'b0;
      end
    end
  endtask

  initial begin
    bus.en_i = 1'b0; bus.usr_req_i = 1'b0; bus.usr_wen_i = 1'b0; bus.usr_addr_i = '0;
    bus.usr_wdata_i = '0; bus.usr_bm_i = '0; bus.cfg_req_i = 1'b0; bus.cfg_wen_i = 1'b0;
    bus.cfg_wdata_i = '0; bus.core_done_i = 1'b0; bus.core_rdata_i = '0; bus.tmo_clr_i = 1'b0;
    test_reset();
    test_user_write();
    test_cfg_read();
    test_round_robin();
    test_timeout();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "bench time limit");
  end

endmodule
